// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed multiply/divide unit for the 16-bit core.
// An accepted start holds the pipeline while the unit iterates. The 2*WIDTH
// result is then presented as hi/lo halves: product for multiply, and
// remainder:quotient for divide.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   start      launch request, sampled only in IDLE
//   multiDiv   01 multiply, 10 divide, 00/11 no operation
//   opA, opB   signed operands (multiplicand/dividend, multiplier/divisor)
//   busy       high whenever the unit is not idle
//   stall      pipeline hold request
//   done       one-cycle pulse, results valid
//   resultHi   product upper half or remainder
//   resultLo   product lower half or quotient
//   divByZero  (only with DIV_BY_ZERO_TRAP_EN) set by a trapped divide by zero
//
// Build option DIV_BY_ZERO_TRAP_EN: a divide by zero goes straight from IDLE
// to DONE and raises divByZero. Without it, a divide by zero runs the full
// latency.
//
// state | meaning
// IDLE  | waiting for an accepted start
// RUN   | one shift-add / restoring-divide iteration per cycle on magnitudes
// FIX   | apply operand signs, register results
// DONE  | done pulse, results valid
module muldiv_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       multiDiv,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] resultHi,
`ifdef DIV_BY_ZERO_TRAP_EN
    output logic [WIDTH-1:0] resultLo,
    output logic             divByZero
`else
    output logic [WIDTH-1:0] resultLo
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    // Multiply: {carry, hi, lo}, multiplier enters in lo.
    // Divide:   {remainder (W+1), quotient}, dividend enters in lo.
    logic [2*WIDTH:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic             is_div_q, is_div_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
`ifdef DIV_BY_ZERO_TRAP_EN
    logic             dbz_q, dbz_d;
`endif

    logic               valid_op, accept;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum, rem_sh, diff;
    logic [WIDTH-1:0]   q_sh;
    logic [2*WIDTH-1:0] prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
`ifdef DIV_BY_ZERO_TRAP_EN
            dbz_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            div0_q   <= div0_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
`ifdef DIV_BY_ZERO_TRAP_EN
            dbz_q    <= dbz_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        div0_d   = div0_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
`ifdef DIV_BY_ZERO_TRAP_EN
        dbz_d    = dbz_q;
`endif

        valid_op = (multiDiv == 2'b01) || (multiDiv == 2'b10);
        accept   = (state_q == S_IDLE) && start && valid_op;
        abs_a    = opA[WIDTH-1] ? -opA : opA;
        abs_b    = opB[WIDTH-1] ? -opB : opB;

        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        // Remainder stays below the divisor (<= 2^(W-1)), so after shifting it
        // still fits in W+1 bits and diff[WIDTH] is a valid sign.
        rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        q_sh   = {acc_q[WIDTH-2:0], 1'b0};
        diff   = rem_sh - {1'b0, opnd_q};
        prod   = acc_q[2*WIDTH-1:0];

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sign_a_d = opA[WIDTH-1];
                    sign_b_d = opB[WIDTH-1];
                    is_div_d = (multiDiv == 2'b10);
                    div0_d   = (opB == '0);
                    count_d  = '0;
                    if (multiDiv == 2'b10) begin
                        opnd_d = abs_b;
                        acc_d  = {{(WIDTH+1){1'b0}}, abs_a};
                    end else begin
                        opnd_d = abs_a;
                        acc_d  = {{(WIDTH+1){1'b0}}, abs_b};
                    end
                    state_d = S_RUN;
`ifdef DIV_BY_ZERO_TRAP_EN
                    dbz_d = 1'b0;
                    if ((multiDiv == 2'b10) && (opB == '0)) begin
                        res_hi_d = opA;
                        res_lo_d = '1;
                        dbz_d    = 1'b1;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    if (!diff[WIDTH]) acc_d = {diff, q_sh | {{(WIDTH-1){1'b0}}, 1'b1}};
                    else              acc_d = {rem_sh, q_sh};
                end else begin
                    if (acc_q[0]) acc_d = {sum, acc_q[WIDTH-1:0]} >> 1;
                    else          acc_d = acc_q >> 1;
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH-1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    // A zero divisor yields quotient all-ones and remainder |opA|;
                    // skipping the quotient sign fix leaves {opA, all-ones}.
                    res_lo_d = ((sign_a_q ^ sign_b_q) && !div0_q) ? -acc_q[WIDTH-1:0]
                                                                   : acc_q[WIDTH-1:0];
                    res_hi_d = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {res_hi_d, res_lo_d} = (sign_a_q ^ sign_b_q) ? -prod : prod;
                end
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign stall    = accept || (state_q == S_RUN) || (state_q == S_FIX);
    assign resultHi = res_hi_q;
    assign resultLo = res_lo_q;
`ifdef DIV_BY_ZERO_TRAP_EN
    assign divByZero = dbz_q;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  multiDiv = 2'b00;
    logic [15:0] opA = 16'h0;
    logic [15:0] opB = 16'h0;
    logic        busy, stall, done;
    logic [15:0] resultHi, resultLo;
`ifdef DIV_BY_ZERO_TRAP_EN
    logic        divByZero;
    localparam int LAT_DBZ = 1;   // DONE directly follows the accept cycle
`else
    localparam int LAT_DBZ = 18;
`endif

    int tests = 0;
    int fails = 0;

    muldiv_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .multiDiv(multiDiv),
        .opA(opA), .opB(opB), .busy(busy), .stall(stall), .done(done),
`ifdef DIV_BY_ZERO_TRAP_EN
        .divByZero(divByZero),
`endif
        .resultHi(resultHi), .resultLo(resultLo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic from the signed-arithmetic definition.
    function automatic logic [31:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                               input logic [1:0] op);
        logic signed [31:0] sa, sb, r;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        if (op == 2'b01) return sa * sb;
        if (b == 16'h0) return {a, 16'hFFFF};
        r = sa % sb;
        return {r[15:0], 16'h0} | {16'h0, 16'((sa / sb))};
    endfunction

    // Cycle-level model: rem_m counts remaining non-idle cycles (DONE when 1).
    int          rem_m = 0;
    logic [31:0] pend = 32'h0;
    logic [15:0] exp_hi = 16'h0, exp_lo = 16'h0;
    logic        exp_dbz = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_m = 0; exp_hi = 16'h0; exp_lo = 16'h0; exp_dbz = 1'b0;
        end else if (rem_m == 0) begin
            if (start && (multiDiv == 2'b01 || multiDiv == 2'b10)) begin
                pend = ref_result(opA, opB, multiDiv);
                exp_dbz = 1'b0;
                rem_m = 18;
`ifdef DIV_BY_ZERO_TRAP_EN
                if (multiDiv == 2'b10 && opB == 16'h0) begin
                    rem_m = 1;
                    {exp_hi, exp_lo} = pend;
                    exp_dbz = 1'b1;
                end
`endif
            end
        end else begin
            rem_m = rem_m - 1;
            if (rem_m == 1) {exp_hi, exp_lo} = pend;
        end
    end

    always @(negedge clk) begin
        check("busy", {31'h0, busy}, {31'h0, rem_m != 0});
        check("done", {31'h0, done}, {31'h0, rem_m == 1});
        check("stall", {31'h0, stall},
              {31'h0, (rem_m > 1) || (rem_m == 0 && start && (multiDiv == 2'b01 || multiDiv == 2'b10))});
        if (rem_m <= 1) check("result", {resultHi, resultLo}, {exp_hi, exp_lo});
`ifdef DIV_BY_ZERO_TRAP_EN
        check("divByZero", {31'h0, divByZero}, {31'h0, exp_dbz});
`endif
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                          input logic [31:0] exp_res, input int exp_lat, input string name);
        int lat;
        bit seen;
        @(posedge clk); #1;
        start = 1'b1; multiDiv = op; opA = a; opB = b;
        @(posedge clk); #1;
        start = 1'b0; multiDiv = 2'b00;
        lat = 0; seen = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1;
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
        end else begin
            check({name, "_lat"}, lat, exp_lat);
            check({name, "_res"}, {resultHi, resultLo}, exp_res);
        end
        @(negedge clk);
    endtask

    logic [15:0] pa [3] = '{16'd5, 16'hFED4, 16'd1234};
    logic [15:0] pb [3] = '{16'd6, 16'd7, 16'hFFF7};
    logic [1:0]  pop [3] = '{2'b01, 2'b10, 2'b01};

    initial begin
        int cyc, nd;
        int t_done [3];
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_out", {busy, stall, done, resultHi, resultLo}, 35'h0);

        run_op(16'd7,    16'hFFFD, 2'b01, 32'hFFFF_FFEB, 18, "mul_7_m3");
        run_op(16'hFFEF, 16'd5,    2'b10, 32'hFFFE_FFFD, 18, "div_m17_5");
        run_op(16'h8000, 16'hFFFF, 2'b10, 32'h0000_8000, 18, "div_ovf");
        run_op(16'h8000, 16'hFFFF, 2'b01, 32'h0000_8000, 18, "mul_corner");
        run_op(16'd100,  16'hFF38, 2'b01, 32'hFFFF_B1E0, 18, "mul_100_m200");
        run_op(16'h7FFF, 16'h7FFF, 2'b01, 32'h3FFF_0001, 18, "mul_max");
        run_op(16'd1000, 16'hFFF9, 2'b10, 32'h0006_FF72, 18, "div_1000_m7");
        run_op(16'h8000, 16'd3,    2'b10, 32'hFFFE_D556, 18, "div_min_3");
        run_op(16'd9,    16'h0,    2'b10, 32'h0009_FFFF, LAT_DBZ, "div0_9");
`ifdef DIV_BY_ZERO_TRAP_EN
        check("dbz_flag", {31'h0, divByZero}, 32'h1);
`endif
        run_op(16'hFFFB, 16'h0,    2'b10, 32'hFFFB_FFFF, LAT_DBZ, "div0_m5");

        // start with no-op encodings is ignored
        @(posedge clk); #1;
        start = 1'b1; multiDiv = 2'b00;
        repeat (3) @(negedge clk);
        check("noop00_busy", {31'h0, busy}, 32'h0);
        multiDiv = 2'b11;
        repeat (3) @(negedge clk);
        check("noop11_busy", {31'h0, busy}, 32'h0);
        start = 1'b0;

        // start held high, ops alternate; accepted only in IDLE
        @(posedge clk); #1;
        start = 1'b1; multiDiv = pop[0]; opA = pa[0]; opB = pb[0];
        cyc = 0; nd = 0;
        while (nd < 3 && cyc < 120) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                t_done[nd] = cyc;
                nd++;
                if (nd < 3) begin
                    multiDiv = pop[nd]; opA = pa[nd]; opB = pb[nd];
                end else begin
                    start = 1'b0;
                end
            end
        end
        if (nd < 3) begin
            tests++; fails++;
            $display("FAIL held_start_timeout: got %0d dones expected 3", nd);
            start = 1'b0;
        end else begin
            check("held_first", t_done[0], 19);
            check("held_gap1", t_done[1] - t_done[0], 19);
            check("held_gap2", t_done[2] - t_done[1], 19);
        end
        repeat (2) @(negedge clk);

        // reset in the middle of RUN
        @(posedge clk); #1;
        start = 1'b1; multiDiv = 2'b01; opA = 16'd1234; opB = 16'd77;
        @(posedge clk); #1;
        start = 1'b0; multiDiv = 2'b00;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", {busy, stall, done, resultHi, resultLo}, 35'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_op(16'd300, 16'd7, 2'b10, 32'h0006_002A, 18, "div_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
